// File: rtl/gcn_pkg.sv
// Shared types and address decode for the GCN data server.
package gcn_pkg;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    localparam int FEATURE_BASE_DEFAULT = 512;

    typedef struct packed {
        logic        hit;
        logic [31:0] row;
    } addr_dec_t;

    // Weight rows occupy RAM rows 0..weight_cols-1; feature rows are stacked directly after them.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr,
                                              input int unsigned weight_cols,
                                              input int unsigned feature_rows,
                                              input int unsigned feature_base);
        addr_dec_t dec;
        dec.hit = 1'b0;
        dec.row = '0;
        if (addr < weight_cols) begin
            dec.hit = 1'b1;
            dec.row = addr;
        end else if (addr >= feature_base && addr < feature_base + feature_rows) begin
            dec.hit = 1'b1;
            dec.row = addr - feature_base + weight_cols;
        end
        return dec;
    endfunction

endpackage

// File: rtl/gcn_data_server_if.sv
// Load / read / COO bus of the GCN data server; range_err exists only with GCN_SRV_RANGE_CHECK_EN.
interface gcn_data_server_if #(
    parameter int WEIGHT_ROWS     = 96,
    parameter int WEIGHT_WIDTH    = 5,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
);
    logic                           load_valid;
    logic                           load_sel;
    logic [ADDRESS_WIDTH-1:0]       load_addr;
    logic [$clog2(WEIGHT_ROWS)-1:0] load_col;
    logic [WEIGHT_WIDTH-1:0]        load_data;
    logic [COO_BW-1:0]              load_data_hi;
    logic                           load_done;
    logic                           enable_read;
    logic [ADDRESS_WIDTH-1:0]       read_address;
    logic [WEIGHT_WIDTH-1:0]        data_out [0:WEIGHT_ROWS-1];
    logic                           data_valid;
    logic [COO_BW-1:0]              coo_address;
    logic [COO_BW-1:0]              coo_out [0:1];
    logic                           ready;
`ifdef GCN_SRV_RANGE_CHECK_EN
    logic                           range_err;
`endif

    modport master (
        output load_valid, load_sel, load_addr, load_col, load_data, load_data_hi, load_done,
        output enable_read, read_address, coo_address,
`ifdef GCN_SRV_RANGE_CHECK_EN
        input  range_err,
`endif
        input  data_out, data_valid, coo_out, ready
    );

    modport slave (
        input  load_valid, load_sel, load_addr, load_col, load_data, load_data_hi, load_done,
        input  enable_read, read_address, coo_address,
`ifdef GCN_SRV_RANGE_CHECK_EN
        output range_err,
`endif
        output data_out, data_valid, coo_out, ready
    );

endinterface

// File: rtl/gcn_row_ram.sv
// Row store with element-granular writes and a registered full-row read port.
module gcn_row_ram #(
    parameter int ROWS  = 9,
    parameter int COLS  = 96,
    parameter int WIDTH = 5,
    parameter int AW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW    = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [CW-1:0]    wcol,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata [0:COLS-1]
);
    logic [WIDTH-1:0] mem_q   [0:ROWS-1][0:COLS-1];
    logic [WIDTH-1:0] rdata_q [0:COLS-1];
    logic [WIDTH-1:0] rdata_d [0:COLS-1];

    // NOTE: the storage array has no reset on purpose; clearing it would need a write port per element and contents must survive reset anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr][wcol] <= wdata;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '{default: '0};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gcn_data_server.sv
// GCN weight/feature/COO data server: LOAD phase fills storage, SERVE phase returns rows.
// Optional macro GCN_SRV_RANGE_CHECK_EN adds the range_err pulse output.
module gcn_data_server
    import gcn_pkg::*;
#(
    parameter int WEIGHT_ROWS     = 96,
    parameter int WEIGHT_WIDTH    = 5,
    parameter int WEIGHT_COLS     = 3,
    parameter int FEATURE_ROWS    = 6,
    parameter int ADDRESS_WIDTH   = 13,
    parameter int FEATURE_BASE    = FEATURE_BASE_DEFAULT,
    parameter int COO_NUM_OF_COLS = 6,
    parameter int COO_BW          = $clog2(COO_NUM_OF_COLS)
) (
    input logic              clk,
    input logic              reset,
    gcn_data_server_if.slave bus
);
    localparam int RAM_ROWS = WEIGHT_COLS + FEATURE_ROWS;
    localparam int RAM_AW   = (RAM_ROWS > 1) ? $clog2(RAM_ROWS) : 1;

    state_e            state_q, state_d;
    addr_dec_t         ld_dec, rd_dec;
    logic              loading, elem_we, coo_we, rd_en;
    logic              data_valid_q, data_valid_d;
    logic [COO_BW-1:0] coo_wcol;
    logic [COO_BW-1:0] coo_src_q [0:COO_NUM_OF_COLS-1];
    logic [COO_BW-1:0] coo_dst_q [0:COO_NUM_OF_COLS-1];
    logic [COO_BW-1:0] coo_out_q [0:1];
    logic [COO_BW-1:0] coo_out_d [0:1];
    logic [WEIGHT_WIDTH-1:0] row_data [0:WEIGHT_ROWS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_LOAD && bus.load_done) begin
            state_d = ST_SERVE;
        end
    end

    always_comb begin
        bus.ready = (state_q == ST_SERVE);
    end

    // Element columns beyond WEIGHT_ROWS are treated like out-of-range addresses.
    always_comb begin
        ld_dec       = decode_addr(32'(bus.load_addr), WEIGHT_COLS, FEATURE_ROWS, FEATURE_BASE);
        rd_dec       = decode_addr(32'(bus.read_address), WEIGHT_COLS, FEATURE_ROWS, FEATURE_BASE);
        coo_wcol     = bus.load_addr[COO_BW-1:0];
        loading      = (state_q == ST_LOAD) && bus.load_valid;
        elem_we      = loading && !bus.load_sel && ld_dec.hit && (32'(bus.load_col) < WEIGHT_ROWS);
        coo_we       = loading && bus.load_sel && (32'(coo_wcol) < COO_NUM_OF_COLS);
        rd_en        = (state_q == ST_SERVE) && bus.enable_read && rd_dec.hit;
        data_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (coo_we) begin
            coo_src_q[coo_wcol] <= bus.load_data[COO_BW-1:0];
            coo_dst_q[coo_wcol] <= bus.load_data_hi;
        end
    end

    always_comb begin
        coo_out_d[0] = '0;
        coo_out_d[1] = '0;
        if (32'(bus.coo_address) < COO_NUM_OF_COLS) begin
            coo_out_d[0] = coo_src_q[bus.coo_address];
            coo_out_d[1] = coo_dst_q[bus.coo_address];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid_q <= 1'b0;
            coo_out_q    <= '{default: '0};
        end else begin
            data_valid_q <= data_valid_d;
            coo_out_q    <= coo_out_d;
        end
    end

    gcn_row_ram #(
        .ROWS  (RAM_ROWS),
        .COLS  (WEIGHT_ROWS),
        .WIDTH (WEIGHT_WIDTH)
    ) u_row_ram (
        .clk   (clk),
        .reset (reset),
        .we    (elem_we),
        .waddr (RAM_AW'(ld_dec.row)),
        .wcol  (bus.load_col),
        .wdata (bus.load_data),
        .re    (rd_en),
        .raddr (RAM_AW'(rd_dec.row)),
        .rdata (row_data)
    );

    assign bus.data_out   = row_data;
    assign bus.data_valid = data_valid_q;
    assign bus.coo_out    = coo_out_q;

`ifdef GCN_SRV_RANGE_CHECK_EN
    logic range_err_q, range_err_d;

    always_comb begin
        range_err_d = (loading && !elem_we && !coo_we) || (bus.enable_read && !rd_dec.hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            range_err_q <= 1'b0;
        end else begin
            range_err_q <= range_err_d;
        end
    end

    assign bus.range_err = range_err_q;
`endif

endmodule
